// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/ifetch_unit.sv
// PC register plus request/grant/response fetch FSM with a single-entry
// decode hand-off, memory timeout and misaligned-target fault capture.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc_in,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr
);

  // Last counter value before a timeout fires; unused when TIMEOUT is 0.
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_clr, cnt_inc;
  logic              load_instr, load_pc, set_fault;
  logic [1:0]        cause_next;
  logic [31:0]       faddr_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REQ;
      pc          <= RESET_PC;
      if_instr    <= '0;
      fault_cause <= FC_NONE;
      fault_addr  <= '0;
      cnt         <= '0;
    end else begin
      state <= state_next;
      if (cnt_clr)
        cnt <= '0;
      else if (cnt_inc)
        cnt <= cnt + CNT_W'(1);
      if (load_instr)
        if_instr <= imem_rdata;
      if (load_pc)
        pc <= npc_in;
      if (set_fault) begin
        fault_cause <= cause_next;
        fault_addr  <= faddr_next;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    load_instr = 1'b0;
    load_pc    = 1'b0;
    set_fault  = 1'b0;
    cause_next = FC_NONE;
    faddr_next = '0;
    case (state)
      REQ: begin
        if (imem_gnt) begin
          state_next = WAIT;
          cnt_clr    = 1'b1;
        end
      end
      WAIT: begin
        // A response arriving on the timeout cycle takes priority.
        if (imem_rvalid) begin
          load_instr = 1'b1;
          state_next = HOLD;
        end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
          state_next = FAULT;
          set_fault  = 1'b1;
          cause_next = FC_TIMEOUT;
          faddr_next = pc;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      HOLD: begin
        if (if_ready) begin
          load_pc = 1'b1;
          if (npc_in[1:0] == 2'b00) begin
            state_next = REQ;
          end else begin
            state_next = FAULT;
            set_fault  = 1'b1;
            cause_next = FC_MISALIGN;
            faddr_next = npc_in;
          end
        end
      end
      FAULT: state_next = FAULT;
      default: state_next = REQ;
    endcase
  end

  // Status outputs are forced low while reset is held, regardless of state.
  assign imem_req    = (state == REQ)   && !rst;
  assign if_valid    = (state == HOLD)  && !rst;
  assign fetch_fault = (state == FAULT) && !rst;
  assign imem_addr   = pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a 4-cycle memory timeout.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc_in;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic        fetch_fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  ifetch_unit #(
    .RESET_PC (32'h0000_3000),
    .TIMEOUT  (4),
    .CNT_W    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .npc_in      (npc_in),
    .pc          (pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .fetch_fault (fetch_fault),
    .fault_cause (fault_cause),
    .fault_addr  (fault_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; npc_in = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; if_ready = 1'b0;
    step();
    check("rst_req",    {31'b0, imem_req},    32'd0);
    check("rst_valid",  {31'b0, if_valid},    32'd0);
    check("rst_fault",  {31'b0, fetch_fault}, 32'd0);
    check("rst_pc",     pc,                   32'h0000_3000);
    check("rst_instr",  if_instr,             32'h0);
    check("rst_cause",  {30'b0, fault_cause}, 32'd0);
    check("rst_faddr",  fault_addr,           32'h0);

    rst = 1'b0;
    step();
    check("req1",       {31'b0, imem_req},    32'd1);
    check("req1_addr",  imem_addr,            32'h0000_3000);

    // Grant withheld with a spurious response present.
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("nognt_req",   {31'b0, imem_req}, 32'd1);
      check("nognt_addr",  imem_addr,         32'h0000_3000);
      check("nognt_instr", if_instr,          32'h0);
    end

    imem_gnt = 1'b1; imem_rvalid = 1'b0;
    step();
    check("wait_req",   {31'b0, imem_req},  32'd0);
    check("wait_valid", {31'b0, if_valid},  32'd0);
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005;
    step();
    check("hold_valid", {31'b0, if_valid},  32'd1);
    check("hold_instr", if_instr,           32'h2008_0005);
    check("hold_pc",    pc,                 32'h0000_3000);

    // Stall in HOLD: stray response and unaligned npc must not disturb anything.
    imem_rdata = 32'hDEAD_BEEF; npc_in = 32'h0000_3006;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", {31'b0, if_valid}, 32'd1);
      check("stall_instr", if_instr,          32'h2008_0005);
      check("stall_pc",    pc,                32'h0000_3000);
    end
    imem_rvalid = 1'b0;
    if_ready = 1'b1; npc_in = 32'h0000_3010;
    step();
    if_ready = 1'b0;
    check("next_req",   {31'b0, imem_req},  32'd1);
    check("next_addr",  imem_addr,          32'h0000_3010);
    check("next_pc",    pc,                 32'h0000_3010);
    check("next_valid", {31'b0, if_valid},  32'd0);

    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0013;
    step();
    imem_rvalid = 1'b0;
    check("f2_instr",   if_instr,           32'h00A0_0013);
    if_ready = 1'b1; npc_in = 32'h0000_3006;
    step();
    if_ready = 1'b0;
    check("mis_fault",  {31'b0, fetch_fault}, 32'd1);
    check("mis_cause",  {30'b0, fault_cause}, 32'd1);
    check("mis_faddr",  fault_addr,           32'h0000_3006);
    check("mis_pc",     pc,                   32'h0000_3006);
    imem_gnt = 1'b1; imem_rvalid = 1'b1; if_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("flt_req",   {31'b0, imem_req},    32'd0);
      check("flt_valid", {31'b0, if_valid},    32'd0);
      check("flt_fault", {31'b0, fetch_fault}, 32'd1);
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0; if_ready = 1'b0;

    rst = 1'b1;
    step();
    check("rec_pc",     pc,                   32'h0000_3000);
    check("rec_fault",  {31'b0, fetch_fault}, 32'd0);
    check("rec_cause",  {30'b0, fault_cause}, 32'd0);
    rst = 1'b0;
    step();
    check("rec_req",    {31'b0, imem_req},    32'd1);

    // Timeout: grant then silence.
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("to_pending", {31'b0, fetch_fault}, 32'd0);
    end
    step();
    check("to_fault",   {31'b0, fetch_fault}, 32'd1);
    check("to_cause",   {30'b0, fault_cause}, 32'd2);
    check("to_faddr",   fault_addr,           32'h0000_3000);

    // Response exactly on the last allowed WAIT cycle.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    repeat (3) step();
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_rvalid = 1'b0;
    check("late_valid", {31'b0, if_valid},    32'd1);
    check("late_fault", {31'b0, fetch_fault}, 32'd0);
    check("late_instr", if_instr,             32'h1234_5678);

    // Wrap to address zero is a legal aligned target.
    if_ready = 1'b1; npc_in = 32'h0000_0000;
    step();
    if_ready = 1'b0;
    check("wrap_req",   {31'b0, imem_req},    32'd1);
    check("wrap_addr",  imem_addr,            32'h0000_0000);
    check("wrap_fault", {31'b0, fetch_fault}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Owns the architectural PC register and fetches instructions from instruction memory. It is the consumer of the next-PC value produced by the next-PC logic: it drives the current `pc` out to that logic and latches its `npc_in` result when decode accepts an instruction. It also fetches through a request/grant/response instruction-memory port, presents one instruction at a time to decode with a valid/ready handshake, and flags misaligned-target and memory-timeout faults.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- TIMEOUT, 16, max cycles spent in WAIT before a timeout fault; 0 disables the timeout.
- CNT_W, 16, width of the timeout counter; must satisfy TIMEOUT < 2**CNT_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- npc_in  in  32  next PC from next-PC logic; sampled only on an accepted decode handshake.
- pc  out  32  current PC register; feeds next-PC logic and the imem address.
- imem_req  out  1  fetch request; asserted only in REQ.
- imem_addr  out  32  equal to pc.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; arrives at least 1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  if_instr/pc valid for decode.
- if_ready  in  1  decode accepts the instruction.
- if_instr  out  32  fetched instruction, registered.
- fetch_fault  out  1  sticky fault flag.
- fault_cause  out  2  00 none, 01 misaligned npc, 10 imem timeout.
- fault_addr  out  32  address associated with the fault.

Behaviour:
- Reset, sampled in the cycle rst=1:
  - pc=RESET_PC, state=REQ, if_instr=0, fault_cause=00, fault_addr=0, counter=0.
  - While rst=1: imem_req=0, if_valid=0, fetch_fault=0.
- States: REQ, WAIT, HOLD, FAULT. Outputs are decoded from state: imem_req=(state==REQ), if_valid=(state==HOLD).
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_gnt: go to WAIT and clear the counter.
  - Otherwise stay in REQ with address stable.
- WAIT:
  - On imem_rvalid: if_instr<=imem_rdata, go to HOLD.
  - Otherwise the counter increments.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no rvalid: go to FAULT, cause=10, fault_addr<=pc.
  - rvalid in the same cycle as the timeout: rvalid wins and no fault is raised.
- HOLD:
  - if_valid=1; if_instr and pc are held stable while if_ready=0.
  - On if_ready and npc_in[1:0]==00: pc<=npc_in, go to REQ.
  - On if_ready and npc_in[1:0]!=00: pc<=npc_in, go to FAULT, cause=01, fault_addr<=npc_in.
- FAULT:
  - imem_req=0, if_valid=0, fetch_fault=1.
  - Terminal; the only exit is rst.
- imem_rvalid outside WAIT is ignored: no state or data change.
- Minimum latency from gnt to if_valid is 2 cycles: gnt@t0, rvalid@t1, if_valid@t2. Peak throughput is 1 instruction per 3 cycles.
- npc_in is treated as an arbitrary 32-bit value; no arithmetic is done here. PC wrap from 32'hFFFF_FFFC to 0 is handled upstream and is legal.
- Reset mid-operation (any state) returns to REQ with RESET_PC on the next cycle. The instruction memory shares rst, so no stale response is in flight after reset.

Decomposition:
- Shared package ifetch_pkg holds:
  - the state enum {REQ, WAIT, HOLD, FAULT};
  - the fault_cause constants FC_NONE=2'b00, FC_MISALIGN=2'b01, FC_TIMEOUT=2'b10;
  - the default RESET_PC constant.
- No sub-module: the timeout counter and FSM stay in one module.

Test Plan:
- Reset then a memory with 1-cycle latency returning 32'h2008_0005 at 32'h3000 → imem_req=1 at cycle 1, if_valid with if_instr=32'h2008_0005, pc=32'h3000 two cycles after gnt.
- HOLD with if_ready=0 for 5 cycles, then if_ready=1 with npc_in=32'h3010 → outputs stable throughout, then pc=32'h3010 and imem_addr=32'h3010 on the next REQ.
- Accept with npc_in=32'h3006 → FAULT; fetch_fault=1, fault_cause=01, fault_addr=32'h3006, imem_req stays 0 for 20 cycles; rst restores pc=32'h3000.
- TIMEOUT=4, gnt but no rvalid → fetch_fault rises 4 cycles after entering WAIT, cause=10, fault_addr=pc.
- TIMEOUT=4, rvalid exactly in the 4th WAIT cycle → HOLD, no fault.
- Spurious imem_rvalid in REQ and HOLD with rdata=32'hDEAD_BEEF → if_instr unchanged; gnt held low for 3 cycles keeps imem_req=1 with a stable address.
